// File: rtl/dff_share_arbiter.sv
// Round-robin sharing of one registered sample datapath (out_q, out_q AND prior out_q) among N requesters.
// Optional ARB_LOCK_EN adds per-requester lock inputs that keep the grant for up to MAX_LOCK transfers.
module dff_share_arbiter #(
  parameter int          N       = 4,
  parameter int          W       = 1,
  parameter logic [W-1:0] RESET_Q = '1
`ifdef ARB_LOCK_EN
  ,
  parameter int          MAX_LOCK = 4
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_q,
  output logic [W-1:0]   out_p,
  output logic           busy
);

  localparam int PW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   data_q, data_d;
  logic [W-1:0]   prod_q, prod_d;

`ifdef ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
`endif

  logic           any_req;
  logic           k_req;
  logic [W-1:0]   k_data;
  logic           accept;
  logic           rotate;
  logic [PW-1:0]  pick;

  // First set request strictly after p, wrapping; p itself is examined last.
  function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] r, input logic [PW-1:0] p);
    logic [PW:0] idx;
    logic        found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, p} + (PW+1)'(i);
      if (idx >= (PW+1)'(N)) idx = idx - (PW+1)'(N);
      if (!found && r[idx[PW-1:0]]) begin
        rr_pick = idx[PW-1:0];
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    prod_d      = prod_q;
`ifdef ARB_LOCK_EN
    lock_cnt_d  = lock_cnt_q;
`endif
    rotate      = 1'b0;

    // ptr_q always equals the granted index while in GRANT.
    any_req = |req;
    k_req   = req[ptr_q];
    k_data  = req_data[ptr_q*W +: W];
    pick    = rr_pick(req, ptr_q);
    accept  = (state_q == GRANT) && k_req && (!out_valid_q || out_ready);

    if (out_ready) out_valid_d = 1'b0;
    if (accept) begin
      out_valid_d = 1'b1;
      data_d      = k_data;
      prod_d      = k_data & data_q;
    end

    case (state_q)
      IDLE: rotate = 1'b1;
      GRANT: begin
        if (accept) begin
`ifdef ARB_LOCK_EN
          if (lock[ptr_q] && (lock_cnt_q != LCW'(MAX_LOCK - 1))) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end else begin
            lock_cnt_d = '0;
            rotate     = 1'b1;
          end
`else
          rotate = 1'b1;
`endif
        end else if (!k_req) begin
`ifdef ARB_LOCK_EN
          lock_cnt_d = '0;
`endif
          rotate = 1'b1;
        end
        // Otherwise the output is full: hold the grant and stall.
      end
      default: rotate = 1'b1;
    endcase

    if (rotate) begin
      if (any_req) begin
        state_d = GRANT;
        gnt_d   = N'(1) << pick;
        ptr_d   = pick;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      data_q      <= RESET_Q;
      prod_q      <= '0;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      prod_q      <= prod_d;
`ifdef ARB_LOCK_EN
      lock_cnt_q  <= lock_cnt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign out_valid = out_valid_q;
  assign out_q     = data_q;
  assign out_p     = prod_q;
  assign busy      = (state_q == GRANT);

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed and random stimulus for dff_share_arbiter (N=4, W=4), checked against a
// transaction-level reference model of the grant/accept/capture rules.
module tb_dff_share_arbiter;
  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           out_ready;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   out_q;
  logic [W-1:0]   out_p;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, last winner, output register contents.
  int m_busy, m_ptr, m_valid, m_q, m_p;

  dff_share_arbiter #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_q     (out_q),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int next_winner(input logic [N-1:0] r, input int last);
    logic [N-1:0] sh;
    for (int off = 1; off <= N; off++) begin
      sh = r >> ((last + off) % N);
      if (sh[0]) return (last + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_ptr   = 0;
    m_valid = 0;
    m_q     = 15;
    m_p     = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rdy);
    logic [N-1:0]   rk;
    logic [N*W-1:0] dk;
    int  w, k, val;
    bit  accept, rearb;
    accept = 0;
    rearb  = 0;
    k      = m_ptr;
    if (m_busy == 0) begin
      rearb = 1;
    end else begin
      rk = r >> k;
      if (!rk[0]) rearb = 1;
      else if (m_valid == 0 || rdy) begin
        accept = 1;
        rearb  = 1;
      end
    end
    if (accept) begin
      dk      = d >> (k * W);
      val     = int'(dk[W-1:0]);
      m_p     = val & m_q;
      m_q     = val;
      m_valid = 1;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (rearb) begin
      w = next_winner(r, m_ptr);
      if (w < 0) m_busy = 0;
      else begin
        m_busy = 1;
        m_ptr  = w;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".gnt"},   32'(gnt),       (m_busy != 0) ? 32'(1 << m_ptr) : 32'h0);
    check({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".q"},     32'(out_q),     32'(m_q));
    check({tag, ".p"},     32'(out_p),     32'(m_p));
    check({tag, ".busy"},  32'(busy),      32'(m_busy));
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] r, input logic [N*W-1:0] d,
                       input logic rdy);
    req       = r;
    req_data  = d;
    out_ready = rdy;
    model_step(r, d, rdy);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    int          eg[5];
    int          eq[5];
    logic [31:0] ra, rb, rc;

    eg = '{2, 4, 8, 1, 2};
    eq = '{1, 12, 5, 10, 3};

    rst = 1'b1;
    req = '0;
    req_data = '0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("reset_gnt",   32'(gnt),       32'h0);
    check("reset_valid", 32'(out_valid), 32'h0);
    check("reset_q",     32'(out_q),     32'hF);
    check("reset_p",     32'(out_p),     32'h0);
    check("reset_busy",  32'(busy),      32'h0);
    #12 rst = 1'b0;

    // Single requester
    cycle("single_req", 4'b0001, 16'h0001, 1'b1);
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_novalid", 32'(out_valid), 32'h0);
    cycle("single_acc", 4'b0001, 16'h0001, 1'b1);
    check("single_q", 32'(out_q), 32'h1);
    check("single_p", 32'(out_p), 32'h1);
    check("single_valid", 32'(out_valid), 32'h1);
    cycle("single_drop", 4'b0000, 16'h0001, 1'b1);
    check("single_idle_gnt", 32'(gnt), 32'h0);
    check("single_idle_busy", 32'(busy), 32'h0);

    // All requesters continuous, full throughput
    for (int i = 0; i < 5; i++) begin
      cycle("all", 4'b1111, 16'hA5C3, 1'b1);
      check("all_gnt", 32'(gnt), 32'(eg[i]));
      check("all_q", 32'(out_q), 32'(eq[i]));
    end

    // Backpressure: grant on requester 1 with a full output
    for (int i = 0; i < 2; i++) begin
      cycle("bp_stall", 4'b1111, 16'hA5C3, 1'b0);
      check("bp_gnt", 32'(gnt), 32'h2);
      check("bp_q", 32'(out_q), 32'h3);
      check("bp_valid", 32'(out_valid), 32'h1);
    end
    cycle("bp_release", 4'b1111, 16'hA5C3, 1'b1);
    check("bp_rel_gnt", 32'(gnt), 32'h4);
    check("bp_rel_q", 32'(out_q), 32'hC);

    // Abandon: requester 2 drops, requester 0 waits
    cycle("abandon", 4'b0001, 16'hA5C3, 1'b0);
    check("abandon_gnt", 32'(gnt), 32'h1);
    check("abandon_q", 32'(out_q), 32'hC);
    check("abandon_valid", 32'(out_valid), 32'h1);

    // Reach gnt=0100 with a full output, then reset between clock edges
    cycle("regrant2", 4'b0100, 16'hA5C3, 1'b0);
    check("regrant2_gnt", 32'(gnt), 32'h4);
    check("regrant2_valid", 32'(out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("async_gnt",   32'(gnt),       32'h0);
    check("async_valid", 32'(out_valid), 32'h0);
    check("async_q",     32'(out_q),     32'hF);
    check("async_p",     32'(out_p),     32'h0);
    check("async_busy",  32'(busy),      32'h0);
    model_reset();
    #2 rst = 1'b0;

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom_range(0, 3);
      cycle("rand", ra[N-1:0], rb[N*W-1:0], rc != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
